// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [31:0]       addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic              err0, err1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_we;
    logic [31:0]       mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        output gnt0, gnt1, done0, done1, err0, err1, rdata, busy,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata, busy,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (IDLE -> ACC -> RSP).
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed port-0 priority; default is round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t            state_q, state_d;
    logic              port_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_req;
    logic              pick1;
    logic              in_range;

    logic              gnt0, gnt1, done0, done1, err0, err1;
    logic              mem_we;
    logic [31:0]       mem_a;
    logic [DATA_W-1:0] mem_wd;

    assign any_req  = bus.req0 | bus.req1;
    assign in_range = (addr_q[31:ADDR_W] == '0);

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    assign pick1 = bus.req1 & ~bus.req0;
`else
    // last_q is the port granted most recently; on a tie the other port wins
    logic last_q;
    assign pick1 = bus.req1 & (~bus.req0 | ~last_q);
`endif

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        err0    = 1'b0;
        err1    = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ACC;
            end
            ACC: begin
                gnt0    = ~port_q;
                gnt1    = port_q;
                // rst in this cycle must abort the write before the edge commits it
                mem_we  = we_q & in_range & ~rst;
                mem_a   = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W-1:0]};
                mem_wd  = wd_q;
                state_d = RSP;
            end
            RSP: begin
                done0   = ~port_q;
                done1   = port_q;
                err0    = ~port_q & ~in_range;
                err1    = port_q & ~in_range;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
            if (state_q == IDLE && any_req) last_q <= pick1;
`endif
            if (state_q == ACC) rdata_q <= (~we_q & in_range) ? bus.mem_rd : '0;
        end
    end

    // Command capture; qualified by state, so no reset is needed
    always_ff @(posedge clk) begin
        if (state_q == IDLE && any_req) begin
            port_q <= pick1;
            we_q   <= pick1 ? bus.we1   : bus.we0;
            addr_q <= pick1 ? bus.addr1 : bus.addr0;
            wd_q   <= pick1 ? bus.wd1   : bus.wd0;
        end
    end

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    assign bus.done0  = done0;
    assign bus.done1  = done1;
    assign bus.err0   = err0;
    assign bus.err1   = err1;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.mem_we = mem_we;
    assign bus.mem_a  = mem_a;
    assign bus.mem_wd = mem_wd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory behind the arbiter
    logic [31:0] mem [256];
    assign bus.mem_rd = mem[bus.mem_a[7:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_a[7:0]] <= bus.mem_wd;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    logic        last_gnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Winner: a lone requester wins; on a tie the port not granted last (or port 0 with priority)
    function automatic logic model_pick(input logic r0, input logic r1);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        return 1'b0;
`else
        return (last_gnt == 1'b1) ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic clear_inputs();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.wd0   = '0;
        bus.wd1   = '0;
    endtask

    task automatic do_reset(input logic pl);
        rst     = 1'b1;
        preload = pl;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        preload  = 1'b0;
        last_gnt = 1'b1;
        if (pl) for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    endtask

    // Called in IDLE, 1 time unit after an edge; returns in IDLE likewise
    task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        logic        win, w, inr;
        logic [31:0] a, d, exp_rd;
        bus.req0 = r0;  bus.req1 = r1;
        bus.we0  = w0;  bus.we1  = w1;
        bus.addr0 = a0; bus.addr1 = a1;
        bus.wd0  = d0;  bus.wd1  = d1;
        win      = model_pick(r0, r1);
        last_gnt = win;
        w   = win ? w1 : w0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        inr = (a[31:8] == 24'd0);
        exp_rd = (!w && inr) ? ref_mem[a[7:0]] : 32'd0;
        @(posedge clk); #1;
        chk1("acc_gnt0", bus.gnt0, !win);
        chk1("acc_gnt1", bus.gnt1, win);
        chk1("acc_mem_we", bus.mem_we, w && inr);
        chk32("acc_mem_a", bus.mem_a, {24'd0, a[7:0]});
        if (w && inr) chk32("acc_mem_wd", bus.mem_wd, d);
        clear_inputs();
        if (w && inr) ref_mem[a[7:0]] = d;
        @(posedge clk); #1;
        chk1("rsp_done0", bus.done0, !win);
        chk1("rsp_done1", bus.done1, win);
        chk1("rsp_err", win ? bus.err1 : bus.err0, !inr);
        chk1("rsp_err_other", win ? bus.err0 : bus.err1, 1'b0);
        chk1("rsp_gnt0", bus.gnt0, 1'b0);
        chk1("rsp_mem_we", bus.mem_we, 1'b0);
        chk32("rsp_rdata", bus.rdata, exp_rd);
        @(posedge clk); #1;
        chk1("idle_busy", bus.busy, 1'b0);
        chk32("idle_rdata_hold", bus.rdata, exp_rd);
    endtask

    // Requests held high across whole transactions (reads of addr 1 / addr 2)
    task automatic held(input logic r0, input logic r1, input int n);
        logic win;
        bus.req0 = r0;  bus.req1 = r1;
        bus.we0  = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 32'd1; bus.addr1 = 32'd2;
        for (int t = 0; t < n; t++) begin
            win      = model_pick(r0, r1);
            last_gnt = win;
            @(posedge clk); #1;
            chk1("held_gnt0", bus.gnt0, !win);
            chk1("held_gnt1", bus.gnt1, win);
            @(posedge clk); #1;
            chk1("held_done0", bus.done0, !win);
            chk1("held_done1", bus.done1, win);
            chk32("held_rdata", bus.rdata, win ? ref_mem[2] : ref_mem[1]);
            @(posedge clk); #1;
            chk1("held_busy_gap", bus.busy, 1'b0);
            chk1("held_done_gap", bus.done0 | bus.done1, 1'b0);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  pat;
        logic [31:0] ra0, ra1;
        int          bad;

        clear_inputs();
        do_reset(1'b1);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_gnt", bus.gnt0 | bus.gnt1, 1'b0);
        chk1("reset_done", bus.done0 | bus.done1, 1'b0);
        chk1("reset_mem_we", bus.mem_we, 1'b0);
        chk32("reset_rdata", bus.rdata, 32'd0);

        // Port 0 read of addr 5
        txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0);
        // Port 1 write then port 0 read back
        txn(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd10, 32'd0, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0, 32'd0);
        // Out-of-range write
        txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 32'h12345678, 32'd0);
        chk32("oor_mem0", mem[0], ref_mem[0]);
        // Out-of-range read on port 1
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h8000_0003, 32'd0, 32'd0);
        txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0);

        // Reset during the ACC cycle of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd20; bus.wd0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk1("rstacc_gnt0", bus.gnt0, 1'b1);
        rst = 1'b1;
        clear_inputs();
        #1;
        chk1("rstacc_mem_we", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_gnt = 1'b1;
        chk1("rstacc_busy", bus.busy, 1'b0);
        chk1("rstacc_gnt", bus.gnt0 | bus.gnt1, 1'b0);
        chk1("rstacc_err", bus.err0 | bus.err1, 1'b0);
        chk32("rstacc_rdata", bus.rdata, 32'd0);
        chk32("rstacc_mem20", mem[20], ref_mem[20]);
        @(posedge clk); #1;
        chk1("rstacc_no_done", bus.done0 | bus.done1, 1'b0);

        // Both requesters held continuously from reset
        do_reset(1'b0);
        held(1'b1, 1'b1, 4);
        // Port 0 alone held across RSP
        held(1'b1, 1'b0, 3);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            pat = 2'($urandom_range(1, 3));
            ra0 = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 15));
            txn(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ra0, ra1, $urandom, $urandom);
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk32("final_mem_diffs", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
